// File: rtl/cl_ocl_cfg_mbox.sv
// OCL cfg-bus responder implementing a host<->fabric mailbox: TX FIFO (host->fabric),
// RX FIFO (fabric->host), status with sticky error bits, and a scratch register.
module cl_ocl_cfg_mbox #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        sh_cl_flr_assert_q,
  input  logic [31:0] cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic        cfg_wr_i,
  input  logic        cfg_rd_i,
  output logic        cfg_ack_o,
  output logic [31:0] cfg_rdata_o,
  output logic        tx_v_o,
  output logic [31:0] tx_data_o,
  input  logic        tx_ready_i,
  input  logic        rx_v_i,
  input  logic [31:0] rx_data_i,
  output logic        rx_ready_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] ONE_P_C = PTR_W'(1'b1);
  localparam logic [31:0]      BAD_C   = 32'hdead_beef;
  localparam logic [5:0] A_TX = 6'd0;
  localparam logic [5:0] A_RX = 6'd1;
  localparam logic [5:0] A_ST = 6'd2;
  localparam logic [5:0] A_SC = 6'd3;

  logic [31:0]      tx_mem_r [FIFO_DEPTH];
  logic [31:0]      rx_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
  logic [CNT_W-1:0] tx_cnt_r, rx_cnt_r;
  logic [31:0]      scratch_r;
  logic             tx_ovf_r, rx_udf_r;
  logic             ack_r;
  logic [31:0]      rdata_r;

  logic [5:0]  idx_s;
  logic        wr_s, rd_s, flr_s;
  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        tx_push_s, tx_pop_s, tx_ovf_set_s;
  logic        rx_push_s, rx_pop_s, rx_udf_set_s;
  logic        st_wr_s, sc_wr_s;
  logic [31:0] status_s, rd_val_s;
  logic        unused_addr_s;

  assign idx_s         = cfg_addr_i[7:2];
  assign unused_addr_s = ^{cfg_addr_i[31:8], cfg_addr_i[1:0]};
  assign flr_s         = sh_cl_flr_assert_q;
  // A simultaneous write and read is treated as a write only.
  assign wr_s          = cfg_wr_i;
  assign rd_s          = cfg_rd_i & ~cfg_wr_i;

  assign tx_full_s  = (tx_cnt_r == DEPTH_C);
  assign tx_empty_s = (tx_cnt_r == ZERO_C);
  assign rx_full_s  = (rx_cnt_r == DEPTH_C);
  assign rx_empty_s = (rx_cnt_r == ZERO_C);

  assign tx_push_s    = wr_s & (idx_s == A_TX) & ~tx_full_s & ~flr_s;
  assign tx_ovf_set_s = wr_s & (idx_s == A_TX) & tx_full_s;
  assign tx_pop_s     = ~tx_empty_s & tx_ready_i;
  assign rx_push_s    = rx_v_i & ~rx_full_s;
  assign rx_pop_s     = rd_s & (idx_s == A_RX) & ~rx_empty_s;
  assign rx_udf_set_s = rd_s & (idx_s == A_RX) & rx_empty_s;
  assign st_wr_s      = wr_s & (idx_s == A_ST);
  assign sc_wr_s      = wr_s & (idx_s == A_SC) & ~flr_s;

  // Status word assembled from pre-cycle counts and sticky bits.
  always_comb begin
    status_s        = 32'h0000_0000;
    status_s[7:0]   = 8'(DEPTH_C - tx_cnt_r);
    status_s[15:8]  = 8'(rx_cnt_r);
    status_s[16]    = tx_ovf_r;
    status_s[17]    = rx_udf_r;
  end

  // Read-data mux by register index.
  always_comb begin
    rd_val_s = BAD_C;
    case (idx_s)
      A_TX:    rd_val_s = 32'h0000_0000;
      A_RX:    rd_val_s = rx_empty_s ? BAD_C : rx_mem_r[rx_rptr_r];
      A_ST:    rd_val_s = status_s;
      A_SC:    rd_val_s = scratch_r;
      default: rd_val_s = BAD_C;
    endcase
  end

  // Bus completion: fixed one-cycle ack, read data held between read acks.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ack_r <= cfg_wr_i | cfg_rd_i;
      if (rd_s) rdata_r <= rd_val_s;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      tx_wptr_r <= {PTR_W{1'b0}};
      tx_rptr_r <= {PTR_W{1'b0}};
      tx_cnt_r  <= ZERO_C;
    end else if (flr_s) begin
      tx_wptr_r <= {PTR_W{1'b0}};
      tx_rptr_r <= {PTR_W{1'b0}};
      tx_cnt_r  <= ZERO_C;
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + ONE_P_C;
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + ONE_P_C;
      tx_cnt_r <= tx_cnt_r + CNT_W'(tx_push_s) - CNT_W'(tx_pop_s);
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      rx_wptr_r <= {PTR_W{1'b0}};
      rx_rptr_r <= {PTR_W{1'b0}};
      rx_cnt_r  <= ZERO_C;
    end else if (flr_s) begin
      rx_wptr_r <= {PTR_W{1'b0}};
      rx_rptr_r <= {PTR_W{1'b0}};
      rx_cnt_r  <= ZERO_C;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + ONE_P_C;
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + ONE_P_C;
      rx_cnt_r <= rx_cnt_r + CNT_W'(rx_push_s) - CNT_W'(rx_pop_s);
    end
  end

  // FIFO storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wptr_r] <= cfg_wdata_i;
    if (rx_push_s) rx_mem_r[rx_wptr_r] <= rx_data_i;
  end

  // Scratch and sticky error bits; a set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      scratch_r <= 32'h0000_0000;
      tx_ovf_r  <= 1'b0;
      rx_udf_r  <= 1'b0;
    end else begin
      if (sc_wr_s) scratch_r <= cfg_wdata_i;
      if (flr_s) begin
        tx_ovf_r <= 1'b0;
        rx_udf_r <= 1'b0;
      end else begin
        tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~(st_wr_s & cfg_wdata_i[16]));
        rx_udf_r <= rx_udf_set_s | (rx_udf_r & ~(st_wr_s & cfg_wdata_i[17]));
      end
    end
  end

  assign cfg_ack_o   = ack_r;
  assign cfg_rdata_o = rdata_r;
  assign tx_v_o      = ~tx_empty_s;
  assign tx_data_o   = tx_empty_s ? 32'h0000_0000 : tx_mem_r[tx_rptr_r];
  assign rx_ready_o  = ~rx_full_s;

endmodule
